// File: rtl/maze_wall_scheduler.sv
// maze_wall_scheduler
//   Owns the live maze wall-enable masks for the VGA wall-drawing logic.
//   A request steps both wall LFSRs, captures the new pattern into shadow
//   registers, and commits it to the live masks only at the start of
//   vertical blank. A frame therefore never shows a half-updated maze.
//
//   Optional feature macro: AUTO_REGEN_EN. When it is defined, a frame
//   counter requests a regeneration every AUTO_FRAMES frames.
//
// Ports
//   clk_pix    in   pixel clock (only clock)
//   reset      in   synchronous, active-low
//   vga_vcnt   in   [10:0] vertical line counter
//   regen_req  in   level or pulse request for a new maze
//   lfsr_h     in   [N_WALLS-1:0] horizontal LFSR value
//   lfsr_v     in   [N_WALLS-1:0] vertical LFSR value
//   lfsr_step  out  enable for both LFSRs
//   wall_h_on  out  [N_WALLS-1:0] live horizontal mask, 1 = draw segment
//   wall_v_on  out  [N_WALLS-1:0] live vertical mask, 1 = draw segment
//   busy       out  high in any state other than IDLE
//   regen_ack  out  one-cycle pulse; the new mask is visible in this cycle
//   gen_id     out  [7:0] commit counter, wraps 255 -> 0
//
// State    | meaning
// IDLE     | waiting for a request (external, pending or automatic)
// STEP     | lfsr_step high for STEP_CYCLES cycles
// CAPTURE  | inverted LFSR values latched into the shadow registers
// WAIT_VB  | waiting for the rising edge of line COMMIT_LINE
// COMMIT   | shadow pattern copied to the live masks, gen_id advanced
module maze_wall_scheduler #(
  parameter int N_WALLS     = 25,
  parameter int STEP_CYCLES = 7,
  parameter int COMMIT_LINE = 480,
  parameter int AUTO_FRAMES = 60
) (
  input  logic               clk_pix,
  input  logic               reset,
  input  logic [10:0]        vga_vcnt,
  input  logic               regen_req,
  input  logic [N_WALLS-1:0] lfsr_h,
  input  logic [N_WALLS-1:0] lfsr_v,
  output logic               lfsr_step,
  output logic [N_WALLS-1:0] wall_h_on,
  output logic [N_WALLS-1:0] wall_v_on,
  output logic               busy,
  output logic               regen_ack,
  output logic [7:0]         gen_id
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_STEP,
    S_CAPTURE,
    S_WAIT_VB,
    S_COMMIT
  } state_t;

  localparam logic [10:0] COMMIT_VCNT = 11'(COMMIT_LINE);
  localparam logic [7:0]  STEP_LOAD   = 8'(STEP_CYCLES - 1);

  state_t             state;
  state_t             state_nxt;
  logic [7:0]         step_cnt;
  logic               pend;
  logic [10:0]        vcnt_q;
  logic [N_WALLS-1:0] sh_h;
  logic [N_WALLS-1:0] sh_v;
  logic               line_edge;
  logic               req_any;
  logic               trigger;

  // Only the first cycle of the commit line counts, so a line that is
  // already active when WAIT_VB is entered is skipped for a full frame.
  assign line_edge = (vga_vcnt == COMMIT_VCNT) && (vcnt_q != COMMIT_VCNT);

`ifdef AUTO_REGEN_EN
  localparam logic [7:0] FRAME_LAST = 8'(AUTO_FRAMES - 1);

  logic [7:0] frame_cnt;
  logic       auto_req;

  // Counts only idle frame edges; an edge that coincides with an accepted
  // request is ignored. The commit edge itself falls while busy, so a full
  // period is AUTO_FRAMES edges.
  always_ff @(posedge clk_pix) begin
    if (!reset) begin
      frame_cnt <= 8'd0;
      auto_req  <= 1'b0;
    end else begin
      auto_req <= 1'b0;
      if (state == S_IDLE && line_edge && !trigger) begin
        if (frame_cnt + 8'd1 == FRAME_LAST) begin
          frame_cnt <= 8'd0;
          auto_req  <= 1'b1;
        end else begin
          frame_cnt <= frame_cnt + 8'd1;
        end
      end
    end
  end

  assign req_any = regen_req | auto_req;
`else
  assign req_any = regen_req;
`endif

  assign trigger = req_any | pend;

  always_comb begin
    state_nxt = state;
    lfsr_step = 1'b0;
    busy      = (state != S_IDLE);
    case (state)
      S_IDLE:    if (trigger) state_nxt = S_STEP;
      S_STEP: begin
        lfsr_step = 1'b1;
        if (step_cnt == 8'd0) state_nxt = S_CAPTURE;
      end
      S_CAPTURE: state_nxt = S_WAIT_VB;
      S_WAIT_VB: if (line_edge) state_nxt = S_COMMIT;
      S_COMMIT:  state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_pix) begin
    if (!reset) begin
      state     <= S_IDLE;
      step_cnt  <= 8'd0;
      pend      <= 1'b0;
      vcnt_q    <= 11'd0;
      sh_h      <= '0;
      sh_v      <= '0;
      wall_h_on <= '0;
      wall_v_on <= '0;
      regen_ack <= 1'b0;
      gen_id    <= 8'd0;
    end else begin
      state     <= state_nxt;
      vcnt_q    <= vga_vcnt;
      regen_ack <= 1'b0;

      // One-deep request memory; further requests while busy merge into it.
      if (state == S_IDLE && trigger) begin
        step_cnt <= STEP_LOAD;
        pend     <= 1'b0;
      end else if (state != S_IDLE && req_any) begin
        pend <= 1'b1;
      end

      if (state == S_STEP && step_cnt != 8'd0) step_cnt <= step_cnt - 8'd1;

      // An LFSR bit of 0 means a wall, hence the inversion.
      if (state == S_CAPTURE) begin
        sh_h <= ~lfsr_h;
        sh_v <= ~lfsr_v;
      end

      // The ack is registered alongside the masks, so both appear together.
      if (state == S_COMMIT) begin
        wall_h_on <= sh_h;
        wall_v_on <= sh_v;
        regen_ack <= 1'b1;
        gen_id    <= gen_id + 8'd1;
      end
    end
  end

endmodule

// File: doc/maze_wall_scheduler.md
# maze_wall_scheduler

Sequencer that owns the maze wall-enable state for the pixel-domain renderer. On request it steps the horizontal and vertical LFSRs, captures a new wall pattern into shadow registers, and commits it to the live wall masks only at the start of vertical blank, so a frame never shows a half-updated maze. It sits between the LFSR pair and the VGA wall-drawing logic in `VGA_Main`, and replaces the free-running `sec_clock` capture.

## Interface

Parameters:
- `N_WALLS`, 25: wall segments per orientation (horizontal_n × vertical_n).
- `STEP_CYCLES`, 7: `lfsr_step` cycles issued per regeneration; legal range 1–255.
- `COMMIT_LINE`, 480: `vga_vcnt` value at which the shadow pattern is committed.
- `AUTO_FRAMES`, 60: frames between automatic regenerations. Used only with `AUTO_REGEN_EN`; legal range 2–255.

Ports:
- `clk_pix`, input, 1: pixel clock. This is the only clock.
- `reset`, input, 1: synchronous, active-low.
- `vga_vcnt`, input, 11: vertical counter from `signal_generation`.
- `regen_req`, input, 1: level or pulse requesting a new maze.
- `lfsr_h`, input, `N_WALLS`: horizontal LFSR output.
- `lfsr_v`, input, `N_WALLS`: vertical LFSR output.
- `lfsr_step`, output, 1: enable for both LFSRs (drives `i_Enable`).
- `wall_h_on`, output, `N_WALLS`: live horizontal mask; 1 = draw segment.
- `wall_v_on`, output, `N_WALLS`: live vertical mask; 1 = draw segment.
- `busy`, output, 1: high in any state other than IDLE.
- `regen_ack`, output, 1: one-cycle pulse in the cycle of commit.
- `gen_id`, output, 8: commit counter; wraps from 255 to 0.

## Operation

- States: IDLE, STEP, CAPTURE, WAIT_VB, COMMIT.
- IDLE:
  - Entered when `trigger` = `regen_req` | `pend` (| `auto_req` with `AUTO_REGEN_EN`).
  - On `trigger`, go to STEP, load `step_cnt` with `STEP_CYCLES`-1, and clear `pend`.
- STEP:
  - `lfsr_step` = 1 every cycle.
  - Go to CAPTURE when `step_cnt` = 0; otherwise decrement `step_cnt`.
- CAPTURE (one cycle):
  - `sh_h` <= ~`lfsr_h`, `sh_v` <= ~`lfsr_v`. An LFSR bit of 0 means a wall.
  - Go to WAIT_VB.
- WAIT_VB:
  - Stay until `line_edge` = (`vga_vcnt` == `COMMIT_LINE`) && (`vcnt_q` != `COMMIT_LINE`).
  - `vcnt_q` is `vga_vcnt` registered every cycle.
- COMMIT (one cycle):
  - `wall_h_on` <= `sh_h`, `wall_v_on` <= `sh_v`.
  - `regen_ack` = 1, `gen_id` += 1.
  - Go to IDLE.
- Request while `busy`: sets `pend` (one deep; extra requests merge). The pending request is serviced from IDLE on the cycle after COMMIT.
- `regen_req` held high: each pass through IDLE starts a new regeneration. The resulting rate is at most one commit per frame.
- Live masks change only in COMMIT. Shadow registers change only in CAPTURE.

## Timing

- Reset values, applied on any clock edge with `reset` = 0:
  - State IDLE.
  - `lfsr_step`, `busy`, `regen_ack`, `pend` all 0.
  - `gen_id` = 0, `step_cnt` = 0.
  - `wall_h_on`, `wall_v_on`, `sh_h`, `sh_v` all 0 (open grid).
  - Frame counter 0.
- Reset mid-operation: the sequence is abandoned with no commit, and any pending request is discarded.
- Request to `lfsr_step` rising: 1 cycle. `regen_req` is registered in IDLE; STEP begins the next cycle.
- `lfsr_step` is high for exactly `STEP_CYCLES` consecutive cycles.
- CAPTURE occurs the cycle after the last step, so the captured values reflect exactly `STEP_CYCLES` LFSR advances.
- Commit happens on the first cycle of line `COMMIT_LINE` after CAPTURE.
  - If CAPTURE ends while `vga_vcnt` already equals `COMMIT_LINE`, there is no edge; wait a full frame.
- `regen_ack` coincides with the first cycle in which the new mask is visible on `wall_*_on`.
- `regen_req` and `line_edge` in the same IDLE cycle: the request is accepted and the edge is ignored.
- `gen_id` 255 → 0 on commit; no flag is raised.

## Configuration

- `AUTO_REGEN_EN` defined:
  - An 8-bit frame counter increments on each `line_edge` in IDLE.
  - On reaching `AUTO_FRAMES`-1 it clears and raises `auto_req` for one cycle, which is ORed into `trigger`.
  - The counter holds, without advancing, while `busy`.
- `AUTO_REGEN_EN` undefined:
  - Counter and `auto_req` are not built.
  - Regeneration happens only via `regen_req`.

## Test plan

- Reset with `STEP_CYCLES`=7, `lfsr_h`=25'h0AAAAAA, `lfsr_v`=0, then one `regen_req` pulse with `vga_vcnt` sweeping 0–524:
  - `lfsr_step` is high exactly 7 cycles.
  - At the first `vga_vcnt`=480 edge: `wall_h_on`=25'h1555555, `wall_v_on`=25'h1FFFFFF, `regen_ack` pulses once, `gen_id`=1.
- `regen_req` pulsed twice during WAIT_VB and once more during STEP:
  - Exactly two commits occur, on consecutive frames.
  - `gen_id` goes 0→1→2.
- CAPTURE completing while `vga_vcnt`=480 is held:
  - No commit in that line.
  - Commit occurs at the next frame's line-480 edge.
- `reset` low for one cycle during WAIT_VB:
  - All outputs return to their reset values.
  - No `regen_ack`, even when line 480 arrives later.
- 256 regenerations: `gen_id` wraps to 0 on the 256th commit.
- `AUTO_REGEN_EN`, `AUTO_FRAMES`=4, no `regen_req`:
  - Regeneration starts every 4th line-480 edge.
  - With the macro undefined, no commit occurs over 20 frames.
